// File: rtl/rapcores_reset_seq.sv
// rapcores_reset_seq: stretches rstb, then releases CHANNELS resetn domains one at a time.
// Latency: 2^STRETCH_BITS+1 edges to first release, STAGE_GAP+1 edges between releases; chan_hold stalls indefinitely.
// Optional watchdog re-sequence is built only with `define RAPCORES_RSTSEQ_WDT_EN.
module rapcores_reset_seq #(
  parameter int CHANNELS     = 4,
  parameter int STRETCH_BITS = 14,
  parameter int STAGE_GAP    = 8,
  parameter int WDT_BITS     = 20
) (
  input  logic                wb_clk_i,
  input  logic                rstb,
  input  logic                sw_rst_req,
  input  logic [CHANNELS-1:0] chan_hold,
  input  logic                wdt_kick,
  output logic [CHANNELS-1:0] resetn_out,
  output logic                seq_busy,
  output logic                seq_done,
  output logic [3:0]          stage_idx,
  output logic                wdt_fired
);

  localparam int               IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [7:0]       GAP_LOAD = 8'(STAGE_GAP);

  typedef enum logic [1:0] {
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } state_t;

  state_t                  state;
  logic [STRETCH_BITS-1:0] stretch_cnt;
  logic [7:0]              gap_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    sw_meta;
  logic                    sw_sync;
  logic                    sw_sync_d;
  logic                    sw_rise;
  logic                    wdt_trip;

  assign stage_idx = 4'(idx);

  // Two-flop synchroniser plus one delay flop so only rising edges re-sequence.
  always_ff @(posedge wb_clk_i or negedge rstb) begin
    if (!rstb) begin
      sw_meta   <= 1'b0;
      sw_sync   <= 1'b0;
      sw_sync_d <= 1'b0;
    end else begin
      sw_meta   <= sw_rst_req;
      sw_sync   <= sw_meta;
      sw_sync_d <= sw_sync;
    end
  end

  assign sw_rise = sw_sync & ~sw_sync_d;

  always_ff @(posedge wb_clk_i or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_STRETCH;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      resetn_out  <= '0;
      seq_busy    <= 1'b1;
      seq_done    <= 1'b0;
    end else if (sw_rise || wdt_trip) begin
      state       <= ST_STRETCH;
      stretch_cnt <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      resetn_out  <= '0;
      seq_busy    <= 1'b1;
      seq_done    <= 1'b0;
    end else begin
      case (state)
        ST_STRETCH: begin
          if (&stretch_cnt) begin
            state   <= ST_RELEASE;
            idx     <= '0;
            gap_cnt <= '0;
          end else begin
            stretch_cnt <= stretch_cnt + STRETCH_BITS'(1);
          end
        end
        ST_RELEASE: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (!chan_hold[idx]) begin
            resetn_out[idx] <= 1'b1;
            if (idx == LAST_IDX) begin
              state    <= ST_RUN;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              idx     <= idx + IDX_W'(1);
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        ST_RUN: begin
          resetn_out <= '1;
          seq_busy   <= 1'b0;
          seq_done   <= 1'b1;
        end
        default: begin
          state <= ST_STRETCH;
        end
      endcase
    end
  end

`ifdef RAPCORES_RSTSEQ_WDT_EN
  logic [WDT_BITS-1:0] wdt_cnt;

  assign wdt_trip = (state == ST_RUN) && (&wdt_cnt);

  // Count is held at zero outside RUN, so it starts fresh on every RUN entry.
  always_ff @(posedge wb_clk_i or negedge rstb) begin
    if (!rstb) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if ((state != ST_RUN) || wdt_kick || wdt_trip || sw_rise) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + WDT_BITS'(1);
      end
      if (wdt_trip && !sw_rise) begin
        wdt_fired <= 1'b1;
      end
    end
  end
`else
  logic [WDT_BITS-1:0] unused_wdt;

  assign unused_wdt = {WDT_BITS{wdt_kick}};
  assign wdt_trip   = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

endmodule

// File: tb/tb_rapcores_reset_seq.sv
// Bench for rapcores_reset_seq: expected output events are queued per scenario and
// matched against events seen on resetn_out/seq_done/seq_busy/wdt_fired.
module tb_rapcores_reset_seq;

  localparam int CH = 4;

  // kind: 0 channel rise, 1 all channels drop, 2 done rise, 3 done fall,
  //       4 busy rise, 5 busy fall, 6 wdt_fired rise
  typedef struct packed {
    int kind;
    int ch;
    int edge_n;
  } ev_t;

  logic          wb_clk_i = 1'b0;
  logic          rstb = 1'b0;
  logic          sw_rst_req = 1'b0;
  logic [CH-1:0] chan_hold = '0;
  logic          wdt_kick = 1'b0;
  logic [CH-1:0] resetn_out;
  logic          seq_busy;
  logic          seq_done;
  logic [3:0]    stage_idx;
  logic          wdt_fired;

  int  cyc = 0;
  int  base = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];
  ev_t e;
  ev_t o;

  rapcores_reset_seq #(
    .CHANNELS    (CH),
    .STRETCH_BITS(4),
    .STAGE_GAP   (2),
    .WDT_BITS    (6)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .rstb      (rstb),
    .sw_rst_req(sw_rst_req),
    .chan_hold (chan_hold),
    .wdt_kick  (wdt_kick),
    .resetn_out(resetn_out),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .stage_idx (stage_idx),
    .wdt_fired (wdt_fired)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  function automatic ev_t mk(input int k, input int c, input int n);
    ev_t r;
    r.kind   = k;
    r.ch     = c;
    r.edge_n = n;
    return r;
  endfunction

  function automatic string ev_str(input ev_t v);
    return $sformatf("kind%0d ch%0d edge%0d", v.kind, v.ch, v.edge_n);
  endfunction

  // Records output events for ncyc edges; optional periodic wdt_kick pulse.
  task automatic watch(input int ncyc, input int kick_per);
    logic [CH-1:0] pr;
    logic pd, pb, pw;
    int rel;
    pr = resetn_out; pd = seq_done; pb = seq_busy; pw = wdt_fired;
    repeat (ncyc) begin
      rel = cyc - base;
      wdt_kick = (kick_per > 0) && (rel != 0) && ((rel % kick_per) == 0);
      @(negedge wb_clk_i);
      rel = cyc - base;
      for (int i = 0; i < CH; i++)
        if (resetn_out[i] && !pr[i]) obs_q.push_back(mk(0, i, rel));
      if ((resetn_out == '0) && (pr != '0)) obs_q.push_back(mk(1, 0, rel));
      if (seq_done && !pd) obs_q.push_back(mk(2, 0, rel));
      if (!seq_done && pd) obs_q.push_back(mk(3, 0, rel));
      if (seq_busy && !pb) obs_q.push_back(mk(4, 0, rel));
      if (!seq_busy && pb) obs_q.push_back(mk(5, 0, rel));
      if (wdt_fired && !pw) obs_q.push_back(mk(6, 0, rel));
      pr = resetn_out; pd = seq_done; pb = seq_busy; pw = wdt_fired;
    end
    wdt_kick = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge wb_clk_i);
    rstb = 1'b0;
    @(negedge wb_clk_i);
    rstb = 1'b1;
    base = cyc;
  endtask

  task automatic push_basic(input int off);
    exp_q.push_back(mk(0, 0, off + 17));
    exp_q.push_back(mk(0, 1, off + 20));
    exp_q.push_back(mk(0, 2, off + 23));
    exp_q.push_back(mk(0, 3, off + 26));
    exp_q.push_back(mk(2, 0, off + 26));
    exp_q.push_back(mk(5, 0, off + 26));
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (resetn_out !== 4'b0000) $display("FAIL reset resetn_out got %b need 0000", resetn_out); else n_pass++;
    n_checks++; if (seq_busy !== 1'b1) $display("FAIL reset seq_busy got %b need 1", seq_busy); else n_pass++;
    n_checks++; if (seq_done !== 1'b0) $display("FAIL reset seq_done got %b need 0", seq_done); else n_pass++;
    n_checks++; if (stage_idx !== 4'd0) $display("FAIL reset stage_idx got %0d need 0", stage_idx); else n_pass++;
    n_checks++; if (wdt_fired !== 1'b0) $display("FAIL reset wdt_fired got %b need 0", wdt_fired); else n_pass++;
  endtask

  task automatic test_basic();
    @(negedge wb_clk_i);
    rstb = 1'b1;
    base = cyc;
    push_basic(0);
    watch(40, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL basic event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL basic extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_hold();
    chan_hold = 4'b0100;
    pulse_rst();
    exp_q.push_back(mk(0, 0, 17));
    exp_q.push_back(mk(0, 1, 20));
    exp_q.push_back(mk(0, 2, 41));
    exp_q.push_back(mk(0, 3, 44));
    exp_q.push_back(mk(2, 0, 44));
    exp_q.push_back(mk(5, 0, 44));
    watch(40, 0);
    n_checks++; if (stage_idx !== 4'd2) $display("FAIL hold stage_idx got %0d need 2", stage_idx); else n_pass++;
    n_checks++; if (seq_busy !== 1'b1) $display("FAIL hold seq_busy got %b need 1", seq_busy); else n_pass++;
    chan_hold = 4'b0000;
    watch(20, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL hold event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL hold extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_sw_req();
    sw_rst_req = 1'b1;
    base = cyc;
    exp_q.push_back(mk(1, 0, 3));
    exp_q.push_back(mk(3, 0, 3));
    exp_q.push_back(mk(4, 0, 3));
    push_basic(3);
    // Request stays high throughout: it must not retrigger.
    watch(45, 0);
    sw_rst_req = 1'b0;
    watch(10, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL swreq event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL swreq extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    pulse_rst();
    exp_q.push_back(mk(0, 0, 17));
    exp_q.push_back(mk(0, 1, 20));
    watch(21, 0);
    n_checks++; if (resetn_out !== 4'b0011) $display("FAIL async pre resetn_out got %b need 0011", resetn_out); else n_pass++;
    #1 rstb = 1'b0;
    #1;
    n_checks++; if (resetn_out !== 4'b0000) $display("FAIL async resetn_out got %b need 0000", resetn_out); else n_pass++;
    n_checks++; if (seq_busy !== 1'b1) $display("FAIL async seq_busy got %b need 1", seq_busy); else n_pass++;
    n_checks++; if (stage_idx !== 4'd0) $display("FAIL async stage_idx got %0d need 0", stage_idx); else n_pass++;
    @(negedge wb_clk_i);
    rstb = 1'b1;
    base = cyc;
    push_basic(0);
    watch(30, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL async event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL async extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

`ifdef RAPCORES_RSTSEQ_WDT_EN
  task automatic test_wdt();
    pulse_rst();
    push_basic(0);
    exp_q.push_back(mk(1, 0, 90));
    exp_q.push_back(mk(3, 0, 90));
    exp_q.push_back(mk(4, 0, 90));
    exp_q.push_back(mk(6, 0, 90));
    watch(100, 0);
    n_checks++; if (wdt_fired !== 1'b1) $display("FAIL wdt sticky got %b need 1", wdt_fired); else n_pass++;
    pulse_rst();
    n_checks++; if (wdt_fired !== 1'b0) $display("FAIL wdt clear got %b need 0", wdt_fired); else n_pass++;
    push_basic(0);
    watch(250, 30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL wdt event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL wdt extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask
`else
  task automatic test_wdt();
    pulse_rst();
    push_basic(0);
    watch(1030, 0);
    n_checks++; if (wdt_fired !== 1'b0) $display("FAIL nowdt wdt_fired got %b need 0", wdt_fired); else n_pass++;
    n_checks++; if (resetn_out !== 4'b1111) $display("FAIL nowdt resetn_out got %b need 1111", resetn_out); else n_pass++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : mk(-1, -1, -1);
      n_checks++; if (o !== e) $display("FAIL nowdt event got %s need %s", ev_str(o), ev_str(e)); else n_pass++;
    end
    n_checks++; if (obs_q.size() !== 0) $display("FAIL nowdt extra events got %0d need 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_sw_req();
    test_async_reset();
    test_wdt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
